// File: rtl/audio_fft_framer.sv
// -----------------------------------------------------------------------------
// audio_fft_framer
//
// Takes stereo sample pairs from the audio codec read handshake, reduces them to
// a single channel (left, right or the average), packs them into fixed-length
// frames in a two-bank ping-pong RAM, and streams each complete frame to an FFT
// core as Avalon-ST beats with sop/eop. Capture and streaming run concurrently;
// a frame that starts while the bank it would land in is still full is dropped
// whole and counted in overrun_count.
//
// Optional feature (macro AUDIO_FRAMER_LOOPBACK_EN): every accepted sample pair
// is registered and handed back to the codec write handshake.
//
// Ports:
//   CLOCK_50         in   sole clock, rising edge
//   reset            in   asynchronous, active-high
//   enable           in   capture enable (low discards any partial frame)
//   read_ready       in   codec has a sample pair available
//   readdata_left    in   codec left sample  [DATA_W]
//   readdata_right   in   codec right sample [DATA_W]
//   read             out  pop strobe to codec (follows read_ready)
//   sink_valid       out  FFT beat valid
//   sink_ready       in   FFT ready
//   sink_sop/eop     out  first / last beat of a frame
//   sink_real        out  sample data [DATA_W]
//   sink_imag        out  constant 0  [DATA_W]
//   sink_error       out  constant 0  [2]
//   frame_count      out  frames fully streamed, wraps [CNT_W]
//   overrun_count    out  frames dropped, saturates at 255 [8]
//   busy             out  a bank is full or a frame is being streamed
//   write_ready      in   (loopback) codec can take a pair
//   write            out  (loopback) write strobe
//   writedata_left/right out (loopback) pair presented to codec [DATA_W]
// -----------------------------------------------------------------------------
module audio_fft_framer #(
    parameter int DATA_W    = 24,
    parameter int FRAME_LEN = 256,
    parameter int CHAN_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              enable,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    output logic              sink_valid,
    input  logic              sink_ready,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_real,
    output logic [DATA_W-1:0] sink_imag,
    output logic [1:0]        sink_error,
    output logic [CNT_W-1:0]  frame_count,
    output logic [7:0]        overrun_count,
    output logic              busy
`ifdef AUDIO_FRAMER_LOOPBACK_EN
    ,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right
`endif
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Channel reduction; the average is computed one bit wider so L+R cannot overflow.
    function automatic logic [DATA_W-1:0] select_sample(input logic [DATA_W-1:0] l,
                                                        input logic [DATA_W-1:0] r);
        logic [DATA_W:0] sum;
        sum = {l[DATA_W-1], l} + {r[DATA_W-1], r};
        if (CHAN_MODE == 32'sd1) begin
            return r;
        end else if (CHAN_MODE == 32'sd2) begin
            return sum[DATA_W:1];
        end else begin
            return l;
        end
    endfunction

    logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

    logic [1:0]        full_r, full_nxt_s;
    logic              wr_bank_r, rd_bank_r;
    logic [IDX_W-1:0]  wr_idx_r, rd_idx_r, rd_idx_nxt_s;
    logic              drop_r;
    state_t            state_r, state_nxt_s;
    logic [DATA_W-1:0] rd_data_r;
    logic              sink_valid_r, sink_sop_r, sink_eop_r;
    logic              valid_nxt_s, sop_nxt_s, eop_nxt_s;
    logic [CNT_W-1:0]  frame_count_r;
    logic [7:0]        overrun_r;
    logic              busy_r;

    logic              cap_s, beat_acc_s, frame_done_s, bank_full_eff_s;
    logic              drop_s, frame_wr_end_s, mem_we_s;
    logic [DATA_W-1:0] sample_s;

    assign read       = read_ready & ~reset;
    assign sample_s   = select_sample(readdata_left, readdata_right);
    assign cap_s      = read_ready & enable;
    assign beat_acc_s = (state_r == ST_STREAM) & sink_valid_r & sink_ready;
    assign frame_done_s = beat_acc_s & (rd_idx_r == LAST_IDX);
    // A bank being released by the streamer this very cycle counts as free.
    assign bank_full_eff_s = full_r[wr_bank_r] & ~(frame_done_s & (rd_bank_r == wr_bank_r));
    // The drop decision is taken on the first sample and held for the whole frame.
    assign drop_s         = (wr_idx_r == ZERO_IDX) ? bank_full_eff_s : drop_r;
    assign frame_wr_end_s = cap_s & (wr_idx_r == LAST_IDX);
    assign mem_we_s       = cap_s & ~drop_s;

    // Bank-full flags: the streamer's release and the writer's set may land together.
    always_comb begin
        full_nxt_s = full_r;
        if (frame_done_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s = full_nxt_s;
        end
        if (frame_wr_end_s && !drop_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s = full_nxt_s;
        end
    end

    // Capture side: write index, bank selection, drop latch and overrun counter.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            wr_idx_r  <= ZERO_IDX;
            drop_r    <= 1'b0;
            overrun_r <= 8'd0;
        end else begin
            full_r <= full_nxt_s;
            if (!enable) begin
                wr_idx_r <= ZERO_IDX;
            end else if (cap_s) begin
                drop_r <= drop_s;
                if (wr_idx_r == LAST_IDX) begin
                    wr_idx_r <= ZERO_IDX;
                    if (drop_s) begin
                        if (overrun_r != 8'hFF) begin
                            overrun_r <= overrun_r + 8'd1;
                        end
                    end else begin
                        wr_bank_r <= ~wr_bank_r;
                    end
                end else begin
                    wr_idx_r <= wr_idx_r + IDX_W'(1);
                end
            end
        end
    end

    // Frame RAM write port (no reset on storage).
    always_ff @(posedge CLOCK_50) begin
        if (mem_we_s) begin
            mem[{wr_bank_r, wr_idx_r}] <= sample_s;
        end
    end

    // Stream FSM: state register, read index, bank pointer and frame counter.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rd_idx_r      <= ZERO_IDX;
            rd_bank_r     <= 1'b0;
            frame_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            rd_idx_r <= rd_idx_nxt_s;
            if (frame_done_s) begin
                rd_bank_r     <= ~rd_bank_r;
                frame_count_r <= frame_count_r + CNT_W'(1);
            end
        end
    end

    // Stream FSM next state and next read index.
    always_comb begin
        state_nxt_s  = state_r;
        rd_idx_nxt_s = rd_idx_r;
        case (state_r)
            ST_IDLE: begin
                rd_idx_nxt_s = ZERO_IDX;
                if (full_r[rd_bank_r]) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rd_idx_nxt_s = ZERO_IDX;
                state_nxt_s  = ST_STREAM;
            end
            ST_STREAM: begin
                if (frame_done_s) begin
                    rd_idx_nxt_s = ZERO_IDX;
                    state_nxt_s  = ST_IDLE;
                end else if (beat_acc_s) begin
                    rd_idx_nxt_s = rd_idx_r + IDX_W'(1);
                    state_nxt_s  = ST_STREAM;
                end else begin
                    rd_idx_nxt_s = rd_idx_r;
                    state_nxt_s  = ST_STREAM;
                end
            end
            default: begin
                rd_idx_nxt_s = ZERO_IDX;
                state_nxt_s  = ST_IDLE;
            end
        endcase
    end

    // Stream FSM outputs, decoded from the next state so they can be registered.
    always_comb begin
        valid_nxt_s = 1'b0;
        sop_nxt_s   = 1'b0;
        eop_nxt_s   = 1'b0;
        if (state_nxt_s == ST_STREAM) begin
            valid_nxt_s = 1'b1;
            sop_nxt_s   = (rd_idx_nxt_s == ZERO_IDX);
            eop_nxt_s   = (rd_idx_nxt_s == LAST_IDX);
        end else begin
            valid_nxt_s = 1'b0;
        end
    end

    // Registered sink outputs; the RAM address follows the next index so a
    // stalled beat re-reads the same word and the data stays stable.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sink_valid_r <= 1'b0;
            sink_sop_r   <= 1'b0;
            sink_eop_r   <= 1'b0;
            rd_data_r    <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            sink_valid_r <= valid_nxt_s;
            sink_sop_r   <= sop_nxt_s;
            sink_eop_r   <= eop_nxt_s;
            busy_r       <= (|full_nxt_s) | (state_nxt_s != ST_IDLE);
            if (valid_nxt_s) begin
                rd_data_r <= mem[{rd_bank_r, rd_idx_nxt_s}];
            end else begin
                rd_data_r <= {DATA_W{1'b0}};
            end
        end
    end

    assign sink_valid    = sink_valid_r;
    assign sink_sop      = sink_sop_r;
    assign sink_eop      = sink_eop_r;
    assign sink_real     = rd_data_r;
    assign sink_imag     = {DATA_W{1'b0}};
    assign sink_error    = 2'b00;
    assign frame_count   = frame_count_r;
    assign overrun_count = overrun_r;
    assign busy          = busy_r;

`ifdef AUDIO_FRAMER_LOOPBACK_EN
    logic              lb_pending_r;
    logic [DATA_W-1:0] lb_left_r, lb_right_r;

    // Loopback holding register: a fresh pair overwrites an unwritten one and
    // the data is zeroed once written so idle outputs read as 0.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lb_pending_r <= 1'b0;
            lb_left_r    <= {DATA_W{1'b0}};
            lb_right_r   <= {DATA_W{1'b0}};
        end else if (read_ready) begin
            lb_pending_r <= 1'b1;
            lb_left_r    <= readdata_left;
            lb_right_r   <= readdata_right;
        end else if (write_ready && lb_pending_r) begin
            lb_pending_r <= 1'b0;
            lb_left_r    <= {DATA_W{1'b0}};
            lb_right_r   <= {DATA_W{1'b0}};
        end
    end

    assign write           = write_ready & lb_pending_r;
    assign writedata_left  = lb_left_r;
    assign writedata_right = lb_right_r;
`endif

endmodule

// File: tb/tb_audio_fft_framer.sv
module tb_audio_fft_framer;

    localparam int DW = 24;
    localparam int FL = 8;

    logic          clk = 1'b0;
    logic          reset, enable, en_mix, read_ready, sink_ready;
    logic [DW-1:0] left, right;

    logic          read, sink_valid, sink_sop, sink_eop, busy;
    logic [DW-1:0] sink_real, sink_imag;
    logic [1:0]    sink_error;
    logic [15:0]   frame_count;
    logic [7:0]    overrun_count;

    logic          m_read, m_valid, m_sop, m_eop, m_busy;
    logic [DW-1:0] m_real, m_imag;
    logic [1:0]    m_error;
    logic [15:0]   m_frames;
    logic [7:0]    m_overrun;

`ifdef AUDIO_FRAMER_LOOPBACK_EN
    logic          wr_a, wr_b;
    logic [DW-1:0] wl_a, wr_la, wl_b, wr_lb;
`endif

    int checks = 0;
    int errors = 0;
    int e;

    always #5 clk = ~clk;

    audio_fft_framer #(.DATA_W(DW), .FRAME_LEN(FL), .CHAN_MODE(0), .CNT_W(16)) dut (
        .CLOCK_50(clk), .reset(reset), .enable(enable), .read_ready(read_ready),
        .readdata_left(left), .readdata_right(right), .read(read),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
        .sink_error(sink_error), .frame_count(frame_count),
        .overrun_count(overrun_count), .busy(busy)
`ifdef AUDIO_FRAMER_LOOPBACK_EN
        , .write_ready(1'b1), .write(wr_a), .writedata_left(wl_a), .writedata_right(wr_la)
`endif
    );

    audio_fft_framer #(.DATA_W(DW), .FRAME_LEN(FL), .CHAN_MODE(2), .CNT_W(16)) dut_mix (
        .CLOCK_50(clk), .reset(reset), .enable(en_mix), .read_ready(read_ready),
        .readdata_left(left), .readdata_right(right), .read(m_read),
        .sink_valid(m_valid), .sink_ready(1'b1), .sink_sop(m_sop),
        .sink_eop(m_eop), .sink_real(m_real), .sink_imag(m_imag),
        .sink_error(m_error), .frame_count(m_frames),
        .overrun_count(m_overrun), .busy(m_busy)
`ifdef AUDIO_FRAMER_LOOPBACK_EN
        , .write_ready(1'b1), .write(wr_b), .writedata_left(wl_b), .writedata_right(wr_lb)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [DW-1:0] l, input logic [DW-1:0] r);
        left       = l;
        right      = r;
        read_ready = 1'b1;
        step();
        read_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_valid(input string tag);
        for (int t = 0; t < 40 && sink_valid !== 1'b1; t++) step();
        check(tag, 32'(sink_valid), 32'd1);
    endtask

    // Expects FL consecutive beats first..first+FL-1 with sink_ready high.
    task automatic expect_frame(input int first);
        wait_valid("frame_start");
        for (int b = 0; b < FL; b++) begin
            check("beat_valid", 32'(sink_valid), 32'd1);
            check("beat_data", 32'(sink_real), 32'(first + b));
            check("beat_sop", 32'(sink_sop), 32'(b == 0));
            check("beat_eop", 32'(sink_eop), 32'(b == FL - 1));
            step();
        end
        check("frame_end_valid", 32'(sink_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; en_mix = 1'b0; read_ready = 1'b0;
        sink_ready = 1'b1; left = '0; right = '0;
        step();
        step();
        // Reset state, and read held low while reset is active.
        read_ready = 1'b1;
        #1;
        check("rst_read", 32'(read), 32'd0);
        read_ready = 1'b0;
        check("rst_valid", 32'(sink_valid), 32'd0);
        check("rst_sop", 32'(sink_sop), 32'd0);
        check("rst_eop", 32'(sink_eop), 32'd0);
        check("rst_real", 32'(sink_real), 32'd0);
        check("rst_imag", 32'(sink_imag), 32'd0);
        check("rst_error", 32'(sink_error), 32'd0);
        check("rst_frames", 32'(frame_count), 32'd0);
        check("rst_overrun", 32'(overrun_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Basic frame 1..8 with exact two-cycle latency from the full flag.
        enable = 1'b1;
        left = 24'd1; read_ready = 1'b1;
        #1;
        check("read_follows", 32'(read), 32'd1);
        for (int i = 1; i <= FL; i++) begin
            left = DW'(i);
            step();
        end
        read_ready = 1'b0;
        check("lat_full_edge", 32'(sink_valid), 32'd0);
        check("busy_full", 32'(busy), 32'd1);
        step();
        check("lat_load", 32'(sink_valid), 32'd0);
        step();
        for (int b = 0; b < FL; b++) begin
            check("f1_valid", 32'(sink_valid), 32'd1);
            check("f1_data", 32'(sink_real), 32'(b + 1));
            check("f1_sop", 32'(sink_sop), 32'(b == 0));
            check("f1_eop", 32'(sink_eop), 32'(b == FL - 1));
            step();
        end
        check("f1_end_valid", 32'(sink_valid), 32'd0);
        check("f1_frames", 32'(frame_count), 32'd1);
        check("f1_overrun", 32'(overrun_count), 32'd0);
        check("f1_busy", 32'(busy), 32'd0);

        // (L+R)/2 mixing on the CHAN_MODE=2 instance.
        enable = 1'b0;
        en_mix = 1'b1;
        feed(24'h7FFFFF, 24'h000001);
        feed(24'h800000, 24'hFFFFFF);
        for (int i = 0; i < FL - 2; i++) feed(24'h000000, 24'h000000);
        en_mix = 1'b0;
        for (int t = 0; t < 40 && m_valid !== 1'b1; t++) step();
        check("mix_valid", 32'(m_valid), 32'd1);
        check("mix_pos", 32'(m_real), 32'h400000);
        check("mix_sop", 32'(m_sop), 32'd1);
        step();
        check("mix_neg", 32'(m_real), 32'hBFFFFF);
        repeat (FL) step();
        check("mix_frames", 32'(m_frames), 32'd1);
        check("main_idle_when_disabled", 32'(frame_count), 32'd1);

        // Both banks fill under back-pressure, third frame dropped.
        pulse_reset();
        enable = 1'b1;
        sink_ready = 1'b0;
        for (int i = 1; i <= 3 * FL; i++) feed(DW'(i), 24'd0);
        check("ovr_count", 32'(overrun_count), 32'd1);
        check("ovr_frames", 32'(frame_count), 32'd0);
        check("ovr_busy", 32'(busy), 32'd1);
        repeat (3) step();
        check("ovr_stall_valid", 32'(sink_valid), 32'd1);
        check("ovr_stall_data", 32'(sink_real), 32'd1);
        check("ovr_stall_sop", 32'(sink_sop), 32'd1);
        sink_ready = 1'b1;
        expect_frame(1);
        expect_frame(FL + 1);
        check("ovr_frames_done", 32'(frame_count), 32'd2);
        check("ovr_count_kept", 32'(overrun_count), 32'd1);
        check("ovr_busy_done", 32'(busy), 32'd0);

        // sink_ready toggling every cycle: no loss, no duplication, stable stalls.
        for (int i = 0; i < FL; i++) feed(DW'(200 + i), 24'd0);
        wait_valid("tog_start");
        e = 0;
        for (int cyc = 0; cyc < 40 && e < FL; cyc++) begin
            check("tog_valid", 32'(sink_valid), 32'd1);
            check("tog_data", 32'(sink_real), 32'(200 + e));
            check("tog_sop", 32'(sink_sop), 32'(e == 0));
            check("tog_eop", 32'(sink_eop), 32'(e == FL - 1));
            sink_ready = cyc[0];
            if (sink_ready) e++;
            step();
        end
        sink_ready = 1'b1;
        check("tog_beats", 32'(e), 32'(FL));
        check("tog_end_valid", 32'(sink_valid), 32'd0);
        check("tog_frames", 32'(frame_count), 32'd3);

        // Partial frame discarded when enable drops.
        for (int i = 0; i < 5; i++) feed(DW'(50 + i), 24'd0);
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int i = 0; i < FL; i++) feed(DW'(100 + i), 24'd0);
        expect_frame(100);
        check("en_frames", 32'(frame_count), 32'd4);

        // Reset in the middle of a stream.
        for (int i = 1; i <= FL; i++) feed(DW'(i), 24'd0);
        wait_valid("mid_start");
        step();
        step();
        check("mid_beat3", 32'(sink_real), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_valid", 32'(sink_valid), 32'd0);
        check("mid_sop", 32'(sink_sop), 32'd0);
        check("mid_eop", 32'(sink_eop), 32'd0);
        check("mid_real", 32'(sink_real), 32'd0);
        check("mid_frames", 32'(frame_count), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < FL; i++) feed(DW'(30 + i), 24'd0);
        expect_frame(30);
        check("post_rst_frames", 32'(frame_count), 32'd1);
        check("post_rst_overrun", 32'(overrun_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_fft_framer.md
Name: audio_fft_framer

Overview:
- Sits between `audio_codec` and the FFT core.
- Accepts stereo samples from the codec read handshake and selects or mixes them into one channel.
- Packs the samples into fixed-length frames in a ping-pong buffer.
- Streams each complete frame to the FFT sink as Avalon-ST with sop/eop.
- Capture and streaming run concurrently. Frames that arrive while both banks are full are dropped whole and counted.

Parameters:
- DATA_W, 24, sample width (signed two's complement).
- FRAME_LEN, 256, samples per frame; power of two, ≥4.
- CHAN_MODE, 0, channel source: 0 = left, 1 = right, 2 = (L+R)/2.
- CNT_W, 16, width of frame_count.

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  capture enable.
- read_ready  in  1  codec has a sample pair available.
- readdata_left  in  DATA_W  codec left sample.
- readdata_right  in  DATA_W  codec right sample.
- read  out  1  accept/pop strobe to codec.
- sink_valid  out  1  FFT beat valid.
- sink_ready  in  1  FFT ready.
- sink_sop  out  1  first beat of frame.
- sink_eop  out  1  last beat of frame.
- sink_real  out  DATA_W  sample data.
- sink_imag  out  DATA_W  constant 0.
- sink_error  out  2  constant 0.
- frame_count  out  CNT_W  frames fully streamed; wraps.
- overrun_count  out  8  frames dropped; saturates at 255.
- busy  out  1  either bank full or streaming in progress.

Behaviour:
- Reset (async): all outputs 0, both bank-full flags clear, wr_bank = 0, rd_bank = 0, wr_idx = 0, stream FSM in IDLE.
- read = read_ready whenever reset is low, independent of enable, so the codec FIFO always drains. A sample pair is accepted on any cycle with read_ready = 1.
- Sample value:
  - CHAN_MODE 0 → left.
  - CHAN_MODE 1 → right.
  - CHAN_MODE 2 → sign-extend both to DATA_W+1 bits, add, arithmetic shift right by 1, truncate to DATA_W.
- Capture, on an accepted sample with enable = 1:
  - If wr_idx == 0, latch drop = full[wr_bank].
  - If not dropping, write mem[wr_bank][wr_idx].
  - Increment wr_idx. On wr_idx == FRAME_LEN-1 the index wraps to 0, then:
    - not dropping: set full[wr_bank] and toggle wr_bank;
    - dropping: overrun_count += 1 (saturating) and keep wr_bank.
- enable low: wr_idx forced to 0 and any partial frame is discarded. Full banks are untouched and streaming continues.
- Stream FSM states:
  - IDLE: when full[rd_bank] is set → LOAD.
  - LOAD: fetch word 0 from synchronous RAM → STREAM.
  - STREAM: present beat rd_idx; advance on sink_valid && sink_ready.
    - After the beat with rd_idx == FRAME_LEN-1 is accepted: clear full[rd_bank], toggle rd_bank, frame_count += 1 (wrapping), → IDLE.
- Streaming rules:
  - sink_sop = 1 only on beat 0; sink_eop = 1 only on beat FRAME_LEN-1.
  - sink_real, sop and eop stay stable while sink_valid = 1 and sink_ready = 0.
  - With sink_ready held high, a frame is FRAME_LEN beats in FRAME_LEN consecutive cycles.
  - First sink_valid is exactly 2 cycles after the edge that sets the full flag.
- Simultaneous events:
  - Set of full[a] and clear of full[b] in the same cycle both take effect.
  - A new frame starting (wr_idx == 0) in the same cycle that its bank is cleared by the streamer counts as not full, so no drop.
- busy = full[0] | full[1] | (state != IDLE).
- Reset asserted mid-frame or mid-stream: immediate return to the reset state; the partial beat stream is abandoned with no eop.

Optional Feature:
- Macro: AUDIO_FRAMER_LOOPBACK_EN.
- Defined: adds ports write_ready (in, 1), write (out, 1), writedata_left and writedata_right (out, DATA_W each).
  - Every accepted sample pair is registered and presented to the codec the next cycle.
  - write = 1 when write_ready = 1 and a registered pair is pending; the pending flag clears on the write.
  - A new pair overwrites an unwritten one.
  - writedata outputs are 0 whenever no pair is pending.
  - Loopback is independent of enable and of drops.
- Undefined: these ports and their logic are absent.

Test Plan:
- FRAME_LEN = 8, CHAN_MODE = 0, sink_ready = 1; feed left samples 1..8 → one frame with beats 1..8, sop on beat 1, eop on beat 8, frame_count = 1, overrun_count = 0.
- CHAN_MODE = 2, L = 0x7FFFFF, R = 0x000001 → sink_real = 0x400000; L = 0x800000, R = 0xFFFFFF → 0xBFFFFF.
- sink_ready = 0, feed 24 samples → frames 1 and 2 fill both banks, frame 3 is dropped, overrun_count = 1. Release ready → beats 1..16 in order, frame_count = 2.
- Toggle sink_ready every cycle during a frame → no beat lost or duplicated; data, sop and eop stay stable while stalled.
- Drop enable after 5 samples, re-raise, feed 8 samples 100..107 → streamed frame is exactly 100..107.
- Assert reset mid-stream at beat 3 → all outputs 0 on the same edge; the next full frame streams normally from sop.
